// File: rtl/divide.sv
`default_nettype none
// ============================================================================
// Module      : divide
// Description : Iterative radix-2 restoring integer divider for the RV64M
//               execute stage. Handles DIV/DIVU/REM/REMU and the 32-bit word
//               forms DIVW/DIVUW/REMW/REMUW. One operation in flight at a time.
//               The result leaves on a writeback-style port (result, valid,
//               rd address, write enable), like the multiplier.
//
// Ports       : clk          rising-edge clock
//               reset        asynchronous active-high reset
//               opr_a_i      dividend
//               opr_b_i      divisor
//               div_instr_i  valid divide operation presented this cycle
//               div_func_i   op select: 0 DIV, 1 DIVU, 2 REM, 3 REMU,
//                            4 DIVW, 5 DIVUW, 6 REMW, 7 REMUW
//                            (bit2 = word form, bit1 = remainder,
//                             bit0 = unsigned)
//               rd_addr_i    destination register
//               stall_i      freezes the unit
//               kill_i       aborts any in-flight operation
//               busy_o       unit occupied, upstream must not issue
//               div_res_o    result, held between pulses
//               valid_res_o  one-cycle result pulse
//               rd_addr_o    destination of the issued result
//               rd_wr_en_o   register write enable (same as valid_res_o)
//
// Revision    : 1.0 - initial release
// ============================================================================
module divide #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] opr_a_i,
    input  logic [XLEN-1:0] opr_b_i,
    input  logic            div_instr_i,
    input  logic [2:0]      div_func_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            stall_i,
    input  logic            kill_i,
    output logic            busy_o,
    output logic [XLEN-1:0] div_res_o,
    output logic            valid_res_o,
    output logic [4:0]      rd_addr_o,
    output logic            rd_wr_en_o
);

    localparam int c_cnt_w = $clog2(XLEN) + 1;
    localparam logic [c_cnt_w-1:0] c_n_full = c_cnt_w'(XLEN);
    localparam logic [c_cnt_w-1:0] c_n_word = c_cnt_w'(32);
    localparam logic [XLEN-1:0] c_most_neg = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // Registered operation context
    logic               r_is_word;
    logic               r_is_rem;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [XLEN-1:0]    r_divisor;
    logic [XLEN-1:0]    r_rem;
    logic [XLEN-1:0]    r_quo;
    logic [c_cnt_w-1:0] r_count;
    logic [4:0]         r_rd;

    // Registered outputs
    logic [XLEN-1:0]    r_res;
    logic [4:0]         r_rd_out;
    logic               r_valid;

    // ---------------- operand decode ----------------
    logic            w_is_word;
    logic            w_is_rem;
    logic            w_is_signed;
    logic            w_sign_a;
    logic            w_sign_b;
    logic [XLEN-1:0] w_a_ext;
    logic [XLEN-1:0] w_b_ext;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic            w_div_zero;
    logic            w_overflow;

    assign w_is_word   = div_func_i[2];
    assign w_is_rem    = div_func_i[1];
    assign w_is_signed = ~div_func_i[0];

    assign w_sign_a = w_is_signed & (w_is_word ? opr_a_i[31] : opr_a_i[XLEN-1]);
    assign w_sign_b = w_is_signed & (w_is_word ? opr_b_i[31] : opr_b_i[XLEN-1]);

    // Word forms ignore the upper operand half: extend from bit 31 according
    // to signedness so a single negation yields the magnitude for both widths.
    assign w_a_ext = w_is_word ? {{(XLEN-32){w_sign_a}}, opr_a_i[31:0]} : opr_a_i;
    assign w_b_ext = w_is_word ? {{(XLEN-32){w_sign_b}}, opr_b_i[31:0]} : opr_b_i;
    assign w_a_mag = w_sign_a ? -w_a_ext : w_a_ext;
    assign w_b_mag = w_sign_b ? -w_b_ext : w_b_ext;

    assign w_div_zero = w_is_word ? (opr_b_i[31:0] == 32'd0) : (opr_b_i == '0);
    assign w_overflow = w_is_signed &
                        (w_is_word ? ((opr_a_i[31:0] == 32'h8000_0000) &&
                                      (opr_b_i[31:0] == 32'hFFFF_FFFF))
                                   : ((opr_a_i == c_most_neg) && (opr_b_i == '1)));

    // ---------------- one restoring step ----------------
    logic [XLEN:0] w_shift;
    logic [XLEN:0] w_diff;
    logic          w_qbit;

    assign w_shift = {r_rem, r_quo[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, r_divisor};
    assign w_qbit  = ~w_diff[XLEN];

    // ---------------- result correction ----------------
    logic [XLEN-1:0] w_q_fix;
    logic [XLEN-1:0] w_r_fix;
    logic [XLEN-1:0] w_sel;
    logic [XLEN-1:0] w_result;

    assign w_q_fix  = r_neg_q ? -r_quo : r_quo;
    assign w_r_fix  = r_neg_r ? -r_rem : r_rem;
    assign w_sel    = r_is_rem ? w_r_fix : w_q_fix;
    assign w_result = r_is_word ? {{(XLEN-32){w_sel[31]}}, w_sel[31:0]} : w_sel;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (kill_i) begin
            w_next_state = IDLE;
        end else if (!stall_i) begin
            case (r_state)
                IDLE: begin
                    if (div_instr_i) begin
                        w_next_state = (w_div_zero | w_overflow) ? FINISH : CALC;
                    end
                end
                CALC: begin
                    if (r_count == c_cnt_w'(1)) begin
                        w_next_state = FINISH;
                    end
                end
                FINISH:  w_next_state = IDLE;
                default: w_next_state = IDLE;
            endcase
        end
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_is_word <= 1'b0;
            r_is_rem  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_divisor <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_count   <= '0;
            r_rd      <= '0;
            r_res     <= '0;
            r_rd_out  <= '0;
            r_valid   <= 1'b0;
        end else begin
            // The pulse lasts one cycle; kill and stall cycles never issue.
            r_valid <= 1'b0;
            if (!kill_i && !stall_i) begin
                case (r_state)
                    IDLE: begin
                        if (div_instr_i) begin
                            r_is_word <= w_is_word;
                            r_is_rem  <= w_is_rem;
                            r_rd      <= rd_addr_i;
                            r_divisor <= w_b_mag;
                            r_count   <= w_is_word ? c_n_word : c_n_full;
                            if (w_div_zero) begin
                                // Preload the final answers; no sign fix-up.
                                r_neg_q <= 1'b0;
                                r_neg_r <= 1'b0;
                                r_quo   <= '1;
                                r_rem   <= opr_a_i;
                            end else if (w_overflow) begin
                                r_neg_q <= 1'b0;
                                r_neg_r <= 1'b0;
                                r_quo   <= opr_a_i;
                                r_rem   <= '0;
                            end else begin
                                r_neg_q <= w_sign_a ^ w_sign_b;
                                r_neg_r <= w_sign_a;
                                r_rem   <= '0;
                                // Word dividends sit in the top half so the
                                // first 32 shifts feed them in.
                                r_quo   <= w_is_word ? {w_a_mag[31:0], {(XLEN-32){1'b0}}}
                                                     : w_a_mag;
                            end
                        end
                    end
                    CALC: begin
                        r_rem   <= w_qbit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
                        r_quo   <= {r_quo[XLEN-2:0], w_qbit};
                        r_count <= r_count - c_cnt_w'(1);
                    end
                    FINISH: begin
                        r_res    <= w_result;
                        r_rd_out <= r_rd;
                        r_valid  <= 1'b1;
                    end
                    default: begin
                        r_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy_o      = (r_state != IDLE);
    assign div_res_o   = r_res;
    assign rd_addr_o   = r_rd_out;
    assign valid_res_o = r_valid;
    assign rd_wr_en_o  = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_divide.sv
`default_nettype none
// ============================================================================
// Module      : tb_divide
// Description : Self-checking bench for divide: directed vector table,
//               kill/stall/reset sequences, and random operations compared
//               against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_divide;

    localparam logic [2:0] DIV   = 3'd0;
    localparam logic [2:0] DIVU  = 3'd1;
    localparam logic [2:0] REM   = 3'd2;
    localparam logic [2:0] REMU  = 3'd3;
    localparam logic [2:0] DIVW  = 3'd4;
    localparam logic [2:0] DIVUW = 3'd5;
    localparam logic [2:0] REMW  = 3'd6;
    localparam logic [2:0] REMUW = 3'd7;

    logic        clk;
    logic        reset;
    logic [63:0] opr_a_i;
    logic [63:0] opr_b_i;
    logic        div_instr_i;
    logic [2:0]  div_func_i;
    logic [4:0]  rd_addr_i;
    logic        stall_i;
    logic        kill_i;
    logic        busy_o;
    logic [63:0] div_res_o;
    logic        valid_res_o;
    logic [4:0]  rd_addr_o;
    logic        rd_wr_en_o;

    int n_checks = 0;
    int n_errors = 0;

    divide #(.XLEN(64)) dut (
        .clk         (clk),
        .reset       (reset),
        .opr_a_i     (opr_a_i),
        .opr_b_i     (opr_b_i),
        .div_instr_i (div_instr_i),
        .div_func_i  (div_func_i),
        .rd_addr_i   (rd_addr_i),
        .stall_i     (stall_i),
        .kill_i      (kill_i),
        .busy_o      (busy_o),
        .div_res_o   (div_res_o),
        .valid_res_o (valid_res_o),
        .rd_addr_o   (rd_addr_o),
        .rd_wr_en_o  (rd_wr_en_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  f;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%016h, expected 0x%016h", name, act, exp);
        end
    endtask

    // Reference: plain language arithmetic plus the ISA special cases.
    function automatic logic [63:0] ref_model(input logic [2:0] f, input logic [63:0] a,
                                              input logic [63:0] b);
        longint      sa, sb;
        int          sa32, sb32;
        logic [31:0] ua32, ub32, r32;
        logic [63:0] r;
        if (!f[2]) begin
            sa = a;
            sb = b;
            if (b == 64'd0)
                r = f[1] ? a : 64'hFFFF_FFFF_FFFF_FFFF;
            else if (f[0])
                r = f[1] ? (a % b) : (a / b);
            else if (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF)
                r = f[1] ? 64'd0 : a;
            else
                r = f[1] ? 64'(sa % sb) : 64'(sa / sb);
        end else begin
            ua32 = a[31:0];
            ub32 = b[31:0];
            sa32 = ua32;
            sb32 = ub32;
            if (ub32 == 32'd0)
                r32 = f[1] ? ua32 : 32'hFFFF_FFFF;
            else if (f[0])
                r32 = f[1] ? (ua32 % ub32) : (ua32 / ub32);
            else if (ua32 == 32'h8000_0000 && ub32 == 32'hFFFF_FFFF)
                r32 = f[1] ? 32'd0 : ua32;
            else
                r32 = f[1] ? 32'(sa32 % sb32) : 32'(sa32 / sb32);
            r = {{32{r32[31]}}, r32};
        end
        return r;
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
        logic zero, ovf;
        zero = f[2] ? (b[31:0] == 32'd0) : (b == 64'd0);
        ovf  = !f[0] && (f[2] ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                              : (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF));
        if (zero || ovf) return 1;
        return f[2] ? 33 : 65;
    endfunction

    // Issue at the next falling edge, then count rising edges until the pulse.
    task automatic run_op(input string name, input logic [2:0] f, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] rd,
                          input logic [63:0] exp_res, input int exp_lat);
        int lat;
        bit seen;
        @(negedge clk);
        div_instr_i = 1'b1;
        div_func_i  = f;
        opr_a_i     = a;
        opr_b_i     = b;
        rd_addr_i   = rd;
        @(posedge clk);
        #1;
        div_instr_i = 1'b0;
        opr_a_i     = {$urandom, $urandom};
        opr_b_i     = {$urandom, $urandom};
        rd_addr_i   = 5'($urandom);
        chk({name, "_busy"}, 64'(busy_o), 64'd1);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (valid_res_o) seen = 1'b1;
        end
        chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({name, "_result"}, div_res_o, exp_res);
        chk({name, "_rd"}, 64'(rd_addr_o), 64'(rd));
        chk({name, "_wr_en"}, 64'(rd_wr_en_o), 64'd1);
        chk({name, "_idle"}, 64'(busy_o), 64'd0);
    endtask

    initial begin
        int pulses;
        int pulse_k;
        logic [63:0] pulse_res;
        logic [4:0]  pulse_rd;
        logic [2:0]  f;
        logic [63:0] a, b;

        reset       = 1'b1;
        div_instr_i = 1'b0;
        div_func_i  = 3'd0;
        opr_a_i     = '0;
        opr_b_i     = '0;
        rd_addr_i   = '0;
        stall_i     = 1'b0;
        kill_i      = 1'b0;

        vecs.push_back('{DIV,   64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 65});
        vecs.push_back('{REM,   64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 65});
        vecs.push_back('{DIV,   64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 65});
        vecs.push_back('{REM,   64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 65});
        vecs.push_back('{DIVU,  64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1});
        vecs.push_back('{REMU,  64'd5, 64'd0, 64'd5, 1});
        vecs.push_back('{DIVW,  64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1});
        vecs.push_back('{DIV,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1});
        vecs.push_back('{REM,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1});
        vecs.push_back('{DIVW,  64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1});
        vecs.push_back('{DIVUW, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 33});
        vecs.push_back('{REMW,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33});
        vecs.push_back('{REMW,  64'hDEAD_BEEF_FFFF_FFF9, 64'h1234_5678_0000_0002, 64'hFFFF_FFFF_FFFF_FFFF, 33});
        vecs.push_back('{DIVUW, 64'hABCD_0000_FFFF_FFFF, 64'h5555_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 33});
        vecs.push_back('{REMUW, 64'h0000_0001_8000_0000, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_8000_0000, 1});
        vecs.push_back('{DIVU,  64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, 65});
        vecs.push_back('{REMU,  64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'hF, 65});
        vecs.push_back('{DIVW,  64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 33});
        vecs.push_back('{DIVW,  64'h1234_5678_8000_0000, 64'h9ABC_DEF0_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1});
        vecs.push_back('{REMUW, 64'd10, 64'd3, 64'd1, 33});
        vecs.push_back('{DIVU,  64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 65});

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 64'(busy_o), 64'd0);
        chk("reset_valid", 64'(valid_res_o), 64'd0);
        chk("reset_res", div_res_o, 64'd0);
        chk("reset_rd", 64'(rd_addr_o), 64'd0);
        chk("reset_wr_en", 64'(rd_wr_en_o), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed table, issued back to back (each accept lands while the
        // previous pulse is high).
        for (int i = 0; i < vecs.size(); i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b,
                   5'(i + 1), vecs[i].exp, vecs[i].lat);
        end
        @(posedge clk);
        #1;
        chk("single_pulse", 64'(valid_res_o), 64'd0);

        // Kill during CALC: kill high in cycle T+10, idle after edge T+11.
        @(negedge clk);
        div_instr_i = 1'b1;
        div_func_i  = DIV;
        opr_a_i     = 64'd1000;
        opr_b_i     = 64'd3;
        rd_addr_i   = 5'd3;
        @(posedge clk);
        #1;
        div_instr_i = 1'b0;
        pulses = 0;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            kill_i = (k == 11);
            @(posedge clk);
            #1;
            if (valid_res_o) pulses++;
        end
        kill_i = 1'b0;
        chk("kill_busy", 64'(busy_o), 64'd0);
        chk("kill_no_pulse", 64'(pulses), 64'd0);
        run_op("after_kill", DIVU, 64'd9, 64'd3, 5'd9, 64'd3, 65);

        // kill together with an issue in IDLE: not accepted
        @(negedge clk);
        div_instr_i = 1'b1;
        div_func_i  = DIVU;
        opr_a_i     = 64'd50;
        opr_b_i     = 64'd5;
        kill_i      = 1'b1;
        @(posedge clk);
        #1;
        div_instr_i = 1'b0;
        kill_i      = 1'b0;
        chk("kill_idle_busy", 64'(busy_o), 64'd0);

        // Stall: 3 cycles mid-CALC, 2 in FINISH, issues ignored while busy.
        @(negedge clk);
        div_instr_i = 1'b1;
        div_func_i  = DIVU;
        opr_a_i     = 64'd1000;
        opr_b_i     = 64'd10;
        rd_addr_i   = 5'd7;
        @(posedge clk);
        #1;
        pulses    = 0;
        pulse_k   = 0;
        pulse_res = '0;
        pulse_rd  = '0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            stall_i     = (k >= 11 && k <= 13) || (k == 68) || (k == 69);
            div_instr_i = (k >= 2 && k <= 60);
            div_func_i  = 3'($urandom);
            opr_a_i     = {$urandom, $urandom};
            opr_b_i     = {$urandom, $urandom};
            rd_addr_i   = 5'($urandom);
            @(posedge clk);
            #1;
            if (valid_res_o) begin
                pulses++;
                pulse_k   = k;
                pulse_res = div_res_o;
                pulse_rd  = rd_addr_o;
            end
        end
        stall_i     = 1'b0;
        div_instr_i = 1'b0;
        chk("stall_pulses", 64'(pulses), 64'd1);
        chk("stall_latency", 64'(pulse_k), 64'd70);
        chk("stall_result", pulse_res, 64'd100);
        chk("stall_rd", 64'(pulse_rd), 64'd7);

        // Reset mid-CALC: outputs clear at once, operation discarded.
        @(negedge clk);
        div_instr_i = 1'b1;
        div_func_i  = DIVU;
        opr_a_i     = 64'd12345;
        opr_b_i     = 64'd5;
        rd_addr_i   = 5'd11;
        @(posedge clk);
        #1;
        div_instr_i = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_busy", 64'(busy_o), 64'd0);
        chk("arst_valid", 64'(valid_res_o), 64'd0);
        chk("arst_res", div_res_o, 64'd0);
        chk("arst_rd", 64'(rd_addr_o), 64'd0);
        chk("arst_wr_en", 64'(rd_wr_en_o), 64'd0);
        @(negedge clk);
        reset  = 1'b0;
        pulses = 0;
        repeat (70) begin
            @(posedge clk);
            #1;
            if (valid_res_o) pulses++;
        end
        chk("arst_no_pulse", 64'(pulses), 64'd0);

        // Random operations against the reference model
        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom);
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: b = $urandom_range(0, 1) ? 64'd0 : {$urandom, 32'd0};
                1: begin
                    a = f[2] ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
                    b = f[2] ? {$urandom, 32'hFFFF_FFFF} : 64'hFFFF_FFFF_FFFF_FFFF;
                end
                2: b = {$urandom, 28'd0, 4'($urandom_range(1, 15))};
                3: b = {$urandom, $urandom} >> $urandom_range(0, 63);
                4: a = 64'($urandom_range(0, 1000));
                default: ;
            endcase
            run_op($sformatf("rnd%0d", i), f, a, b, 5'($urandom),
                   ref_model(f, a, b), ref_lat(f, a, b));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
